// File: rtl/util_timestamp_gate_pkg.sv
// Purpose: shared definitions for the DAC-side timestamp gate (FSM states, late-policy codes, header sizing).
// Latency: none, declarations only.
// Backpressure: not applicable.
package util_timestamp_gate_pkg;

    // Gate FSM states.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HDR   = 3'd1,
        ST_CHECK = 3'd2,
        ST_WAIT  = 3'd3,
        ST_PASS  = 3'd4,
        ST_DROP  = 3'd5
    } state_t;

    // What to do with a block whose header time has already passed.
    localparam int LATE_DROP    = 0;
    localparam int LATE_FORWARD = 1;

    // Number of stream beats that carry one timestamp header.
    function automatic int ts_beats(input int ts_width, input int data_width);
        return (ts_width + data_width - 1) / data_width;
    endfunction

endpackage

// File: rtl/util_timestamp_gate_hdr.sv
// Purpose: assembles a multi-beat timestamp header, least-significant word first.
// Latency: header register valid the cycle after the done strobe.
// Backpressure: none; the parent only asserts beat when it is accepting a stream beat.
//
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset
//   clear        discard any partially assembled header
//   beat, data   one accepted header word
//   header       assembled header value
//   done         strobe coinciding with the last header word
module util_timestamp_gate_hdr
    import util_timestamp_gate_pkg::*;
#(
    parameter int DATA_WIDTH      = 64,
    parameter int TIMESTAMP_WIDTH = 64,
    parameter int TS_BEATS        = ts_beats(TIMESTAMP_WIDTH, DATA_WIDTH)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clear,
    input  logic                       beat,
    input  logic [DATA_WIDTH-1:0]      data,
    output logic [TIMESTAMP_WIDTH-1:0] header,
    output logic                       done
);

    localparam int IDX_W = (TS_BEATS > 1) ? $clog2(TS_BEATS) : 1;
    localparam int BUF_W = TS_BEATS * DATA_WIDTH;

    logic [IDX_W-1:0] idx;
    logic [BUF_W-1:0] hdr_buf;
    logic             last;

    assign last = (int'(idx) == TS_BEATS - 1);
    assign done = beat && last && !clear;

    // Word index restarts on every new header so a discarded partial header
    // never shifts the alignment of the next one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx <= '0;
        end else if (clear || done) begin
            idx <= '0;
        end else if (beat) begin
            idx <= idx + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hdr_buf <= '0;
        end else if (beat && !clear) begin
            for (int i = 0; i < TS_BEATS; i++) begin
                if (int'(idx) == i) begin
                    hdr_buf[i*DATA_WIDTH +: DATA_WIDTH] <= data;
                end
            end
        end
    end

    assign header = hdr_buf[TIMESTAMP_WIDTH-1:0];

endmodule

// File: rtl/util_timestamp_gate.sv
// Purpose: strips periodic timestamp headers and releases each block when the sample counter reaches its header.
// Latency: 0 cycles for data in PASS; at least 1 cycle from last header word to gate decision.
// Backpressure: m_axis_ready feeds straight through to s_axis_ready while passing; ready held low while waiting.
//
// Ports:
//   dac_clk, resetn                  sole clock, asynchronous active-low reset
//   timestamp                        free-running sample counter
//   timestamp_every                  data beats per block, 0 selects bypass
//   s_axis_*                         input stream and transfer-active flag
//   m_axis_*                         output stream plus one-cycle flush pulse
//   clr_status                       synchronous clear of the status counters
//   late_count/early_count/underflow_count  saturating status counters
module util_timestamp_gate
    import util_timestamp_gate_pkg::*;
#(
    parameter int DATA_WIDTH      = 64,
    parameter int TIMESTAMP_WIDTH = 64,
    parameter int EARLY_LIMIT     = 100,
    parameter int LATE_POLICY     = LATE_DROP,
    parameter int COUNT_WIDTH     = 16
) (
    input  logic                       dac_clk,
    input  logic                       resetn,
    input  logic [TIMESTAMP_WIDTH-1:0] timestamp,
    input  logic [31:0]                timestamp_every,
    input  logic                       s_axis_valid,
    output logic                       s_axis_ready,
    input  logic [DATA_WIDTH-1:0]      s_axis_data,
    input  logic                       s_axis_xfer_req,
    output logic                       m_axis_valid,
    input  logic                       m_axis_ready,
    output logic [DATA_WIDTH-1:0]      m_axis_data,
    output logic                       m_axis_flush,
    input  logic                       clr_status,
    output logic [COUNT_WIDTH-1:0]     late_count,
    output logic [COUNT_WIDTH-1:0]     early_count,
    output logic [COUNT_WIDTH-1:0]     underflow_count
);

    localparam int TS_BEATS = ts_beats(TIMESTAMP_WIDTH, DATA_WIDTH);
    localparam logic signed [TIMESTAMP_WIDTH-1:0] EARLY_MAX = TIMESTAMP_WIDTH'(EARLY_LIMIT);
    localparam logic [COUNT_WIDTH-1:0] CNT_MAX = '1;

    state_t                       state;
    state_t                       state_nxt;
    logic [31:0]                  beat_cnt;
    logic                         bypass;
    logic                         flush_q;
    logic                         flush_nxt;
    logic [TIMESTAMP_WIDTH-1:0]   header;
    logic                         hdr_done;
    logic signed [TIMESTAMP_WIDTH-1:0] diff;
    logic                         is_late;
    logic                         is_early;
    logic                         gate_open;
    logic                         pass_act;
    logic                         beat_acc;
    logic                         drop_acc;
    logic                         last_beat;
    logic                         to_drop;
    logic                         late_inc;
    logic                         early_inc;
    logic                         under_inc;

    util_timestamp_gate_hdr #(
        .DATA_WIDTH      (DATA_WIDTH),
        .TIMESTAMP_WIDTH (TIMESTAMP_WIDTH),
        .TS_BEATS        (TS_BEATS)
    ) u_hdr (
        .clk    (dac_clk),
        .rst_n  (resetn),
        .clear  (state != ST_HDR),
        .beat   ((state == ST_HDR) && s_axis_valid),
        .data   (s_axis_data),
        .header (header),
        .done   (hdr_done)
    );

    // Modular difference read as signed, so counter wrap needs no special case.
    assign diff     = signed'(header - timestamp);
    assign is_late  = diff[TIMESTAMP_WIDTH-1];
    assign is_early = !is_late && (diff > EARLY_MAX);

    // The waiting block is released in the very cycle the counter reaches the
    // header, so the first beat lines up exactly with its timestamp.
    assign gate_open = (state == ST_WAIT) && (is_late || (diff == '0));
    assign pass_act  = (state == ST_PASS) || gate_open;
    assign beat_acc  = pass_act && s_axis_valid && m_axis_ready;
    assign drop_acc  = (state == ST_DROP) && s_axis_valid;
    // <= 1 keeps a zero block length from wrapping the counter.
    assign last_beat = (beat_cnt <= 32'd1);
    assign to_drop   = (state == ST_CHECK) &&
                       ((is_late && (LATE_POLICY != LATE_FORWARD)) || is_early);

    // State register
    always_ff @(posedge dac_clk or negedge resetn) begin
        if (!resetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (s_axis_xfer_req) begin
                    state_nxt = (timestamp_every == 32'd0) ? ST_PASS : ST_HDR;
                end
            end
            ST_HDR: begin
                if (hdr_done) begin
                    state_nxt = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (to_drop) begin
                    state_nxt = ST_DROP;
                end else if (is_late) begin
                    state_nxt = ST_PASS;
                end else begin
                    state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (gate_open) begin
                    state_nxt = (beat_acc && last_beat) ? ST_HDR : ST_PASS;
                end
            end
            ST_PASS: begin
                if (!bypass && beat_acc && last_beat) begin
                    state_nxt = ST_HDR;
                end
            end
            ST_DROP: begin
                if (drop_acc && last_beat) begin
                    state_nxt = ST_HDR;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (!s_axis_xfer_req) begin
            state_nxt = ST_IDLE;
        end
    end

    // Output logic
    always_comb begin
        s_axis_ready = 1'b0;
        m_axis_valid = 1'b0;
        case (state)
            ST_HDR, ST_DROP: s_axis_ready = 1'b1;
            ST_WAIT, ST_PASS: begin
                if (pass_act) begin
                    s_axis_ready = m_axis_ready;
                    m_axis_valid = s_axis_valid;
                end
            end
            default: ;
        endcase
    end

    assign m_axis_data  = s_axis_data;
    assign m_axis_flush = flush_q;

    // Flush goes out on a block rejection or on transfer abort. Both land in
    // states with m_axis_valid low; back-to-back triggers merge into one pulse.
    assign flush_nxt = (((state != ST_IDLE) && !s_axis_xfer_req) || to_drop) && !flush_q;

    always_ff @(posedge dac_clk or negedge resetn) begin
        if (!resetn) begin
            beat_cnt <= '0;
            bypass   <= 1'b0;
            flush_q  <= 1'b0;
        end else begin
            flush_q <= flush_nxt;
            if (state == ST_IDLE) begin
                bypass <= (timestamp_every == 32'd0);
            end
            if (hdr_done) begin
                beat_cnt <= timestamp_every;
            end else if ((beat_acc && !bypass) || drop_acc) begin
                beat_cnt <= beat_cnt - 32'd1;
            end
        end
    end

    // Status counters: clear wins over increment, saturate at all-ones.
    function automatic logic [COUNT_WIDTH-1:0] sat_step(
        input logic [COUNT_WIDTH-1:0] cnt,
        input logic                   inc,
        input logic                   clr
    );
        if (clr) begin
            return '0;
        end
        if (inc && (cnt != CNT_MAX)) begin
            return cnt + 1'b1;
        end
        return cnt;
    endfunction

    assign late_inc  = (state == ST_CHECK) && is_late;
    assign early_inc = (state == ST_CHECK) && is_early;
    assign under_inc = pass_act && m_axis_ready && !s_axis_valid;

    always_ff @(posedge dac_clk or negedge resetn) begin
        if (!resetn) begin
            late_count      <= '0;
            early_count     <= '0;
            underflow_count <= '0;
        end else begin
            late_count      <= sat_step(late_count,      late_inc,  clr_status);
            early_count     <= sat_step(early_count,     early_inc, clr_status);
            underflow_count <= sat_step(underflow_count, under_inc, clr_status);
        end
    end

endmodule

// File: tb/tb_util_timestamp_gate.sv
// Purpose: self-checking bench for util_timestamp_gate (32-bit beats, 64-bit timestamps, two-word headers).
// Latency: expects zero-cycle pass-through and first beat exactly at the header time.
// Backpressure: downstream always ready; upstream stalls wherever the gate holds ready low.
module tb_util_timestamp_gate;

    localparam int DW = 32;
    localparam int TW = 64;
    localparam int CW = 16;

    logic          dac_clk = 1'b0;
    logic          resetn;
    logic [TW-1:0] timestamp;
    logic [31:0]   timestamp_every;
    logic          s_axis_valid;
    logic          s_axis_ready;
    logic [DW-1:0] s_axis_data;
    logic          s_axis_xfer_req;
    logic          m_axis_valid;
    logic          m_axis_ready;
    logic [DW-1:0] m_axis_data;
    logic          m_axis_flush;
    logic          clr_status;
    logic [CW-1:0] late_count;
    logic [CW-1:0] early_count;
    logic [CW-1:0] underflow_count;

    typedef struct {
        logic [DW-1:0] data;
        bit            chk_ts;
        logic [TW-1:0] ts;
    } exp_t;

    exp_t          sb[$];
    int            tests     = 0;
    int            fails     = 0;
    int            flush_cnt = 0;
    logic          flush_prev = 1'b0;
    bit            ts_jump   = 1'b0;
    logic [TW-1:0] ts_jump_val = '0;

    util_timestamp_gate #(
        .DATA_WIDTH      (DW),
        .TIMESTAMP_WIDTH (TW),
        .EARLY_LIMIT     (100),
        .LATE_POLICY     (0),
        .COUNT_WIDTH     (CW)
    ) dut (
        .dac_clk         (dac_clk),
        .resetn          (resetn),
        .timestamp       (timestamp),
        .timestamp_every (timestamp_every),
        .s_axis_valid    (s_axis_valid),
        .s_axis_ready    (s_axis_ready),
        .s_axis_data     (s_axis_data),
        .s_axis_xfer_req (s_axis_xfer_req),
        .m_axis_valid    (m_axis_valid),
        .m_axis_ready    (m_axis_ready),
        .m_axis_data     (m_axis_data),
        .m_axis_flush    (m_axis_flush),
        .clr_status      (clr_status),
        .late_count      (late_count),
        .early_count     (early_count),
        .underflow_count (underflow_count)
    );

    always #5 dac_clk = ~dac_clk;

    // Sample counter: advances 2 ns after each rising edge, so it is stable
    // around both the stimulus (falling edge) and the DUT sampling edge.
    initial begin
        timestamp = 64'd1000;
        forever begin
            @(posedge dac_clk);
            #2;
            if (ts_jump) begin
                timestamp = ts_jump_val;
                ts_jump   = 1'b0;
            end else begin
                timestamp = timestamp + 64'd1;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [DW-1:0] d, input bit c, input logic [TW-1:0] t);
        exp_t e;
        e.data   = d;
        e.chk_ts = c;
        e.ts     = t;
        sb.push_back(e);
    endtask

    // Offer one beat from a falling edge; returns on the falling edge after acceptance.
    task automatic send(input logic [DW-1:0] d);
        int   n;
        logic acc;
        n = 0;
        s_axis_valid = 1'b1;
        s_axis_data  = d;
        do begin
            #4;
            acc = s_axis_ready;
            @(negedge dac_clk);
            n++;
        end while (!acc && n < 300);
        s_axis_valid = 1'b0;
        if (!acc) begin
            check("send_accept_timeout", 64'(acc), 64'd1);
        end
    endtask

    task automatic send_hdr(input logic [TW-1:0] h);
        send(h[31:0]);
        send(h[63:32]);
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 64) begin
            @(negedge dac_clk);
            n++;
        end
        check(tag, 64'(sb.size()), 64'd0);
    endtask

    // Output monitor: scoreboard pop, exact release time, flush rules.
    initial begin
        forever begin
            @(negedge dac_clk);
            #4;
            if (m_axis_flush) begin
                flush_cnt++;
                check("flush_vs_valid", 64'(m_axis_valid), 64'd0);
                check("flush_one_cycle", 64'(flush_prev), 64'd0);
            end
            flush_prev = m_axis_flush;
            if (m_axis_valid && m_axis_ready) begin
                tests++;
                assert (sb.size() != 0) else begin
                    fails++;
                    $error("FAIL unexpected_beat: observed data %0h, required no output", m_axis_data);
                end
                if (sb.size() != 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    check("beat_data", 64'(m_axis_data), 64'(e.data));
                    if (e.chk_ts) begin
                        check("beat_time", timestamp, e.ts);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d fails=%0d", tests, fails);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [TW-1:0] h;
        resetn          = 1'b0;
        s_axis_valid    = 1'b0;
        s_axis_data     = 32'hCAFE_0001;
        s_axis_xfer_req = 1'b0;
        m_axis_ready    = 1'b1;
        clr_status      = 1'b0;
        timestamp_every = 32'd0;

        // Reset state
        repeat (3) @(negedge dac_clk);
        #4;
        check("rst_s_ready", 64'(s_axis_ready), 64'd0);
        check("rst_m_valid", 64'(m_axis_valid), 64'd0);
        check("rst_flush", 64'(m_axis_flush), 64'd0);
        check("rst_late", 64'(late_count), 64'd0);
        check("rst_early", 64'(early_count), 64'd0);
        check("rst_underflow", 64'(underflow_count), 64'd0);
        check("rst_data_follow", 64'(m_axis_data), 64'hCAFE_0001);
        @(negedge dac_clk);
        resetn = 1'b1;
        @(negedge dac_clk);

        // Bypass: 48 beats straight through, no headers
        timestamp_every = 32'd0;
        s_axis_xfer_req = 1'b1;
        for (int i = 1; i <= 48; i++) begin
            push(DW'(i), 1'b0, '0);
            send(DW'(i));
        end
        drain("bypass_drain");
        check("bypass_no_flush", 64'(flush_cnt), 64'd0);
        check("bypass_late", 64'(late_count), 64'd0);
        check("bypass_early", 64'(early_count), 64'd0);
        s_axis_xfer_req = 1'b0;
        repeat (3) @(negedge dac_clk);
        check("xfer_drop_flush", 64'(flush_cnt), 64'd1);

        // Late header: block of 4 dropped, one flush, late_count 1
        timestamp_every = 32'd4;
        s_axis_xfer_req = 1'b1;
        h = timestamp - 64'd10;
        send_hdr(h);
        for (int i = 0; i < 4; i++) send(DW'(32'hDEAD_0000 + i));
        @(negedge dac_clk);
        check("late_count", 64'(late_count), 64'd1);
        check("late_flush", 64'(flush_cnt), 64'd2);
        check("late_early_cnt", 64'(early_count), 64'd0);

        // On-time header after the late one
        h = timestamp + 64'd6;
        for (int i = 0; i < 4; i++) push(DW'(32'h200 + i), 1'b1, h + 64'(i));
        send_hdr(h);
        for (int i = 0; i < 4; i++) send(DW'(32'h200 + i));
        drain("ontime_drain");

        // Early by 5: held until timestamp == header, then back-to-back
        h = timestamp + 64'd5;
        for (int i = 0; i < 4; i++) push(DW'(32'h300 + i), 1'b1, h + 64'(i));
        send_hdr(h);
        for (int i = 0; i < 4; i++) send(DW'(32'h300 + i));
        drain("early5_drain");
        check("early5_early_cnt", 64'(early_count), 64'd0);
        check("early5_flush", 64'(flush_cnt), 64'd2);

        // Early by 8 across counter wrap, two-word header
        ts_jump_val = 64'hFFFF_FFFF_FFFF_FFFC;
        ts_jump     = 1'b1;
        @(negedge dac_clk);
        h = timestamp + 64'd8;
        for (int i = 0; i < 4; i++) push(DW'(32'h400 + i), 1'b1, h + 64'(i));
        send_hdr(h);
        for (int i = 0; i < 4; i++) send(DW'(32'h400 + i));
        drain("wrap8_drain");
        check("wrap8_late_cnt", 64'(late_count), 64'd1);

        // Too early: dropped with flush, early_count 1
        h = timestamp + 64'd200;
        send_hdr(h);
        for (int i = 0; i < 4; i++) send(DW'(32'hBAD0_0000 + i));
        @(negedge dac_clk);
        check("tooearly_early_cnt", 64'(early_count), 64'd1);
        check("tooearly_flush", 64'(flush_cnt), 64'd3);
        check("tooearly_sb_empty", 64'(sb.size()), 64'd0);

        // Abort mid-PASS with clr_status during an underflow cycle
        h = timestamp + 64'd5;
        push(DW'(32'h500), 1'b1, h);
        push(DW'(32'h501), 1'b1, h + 64'd1);
        send_hdr(h);
        send(DW'(32'h500));
        send(DW'(32'h501));
        repeat (2) @(negedge dac_clk);
        check("underflow_seen", 64'(underflow_count != '0), 64'd1);
        clr_status      = 1'b1;
        s_axis_xfer_req = 1'b0;
        @(negedge dac_clk);
        clr_status = 1'b0;
        #4;
        check("abort_s_ready", 64'(s_axis_ready), 64'd0);
        check("abort_m_valid", 64'(m_axis_valid), 64'd0);
        check("abort_flush", 64'(m_axis_flush), 64'd1);
        check("clr_late", 64'(late_count), 64'd0);
        check("clr_early", 64'(early_count), 64'd0);
        check("clr_underflow", 64'(underflow_count), 64'd0);
        @(negedge dac_clk);
        #4;
        check("abort_flush_single", 64'(m_axis_flush), 64'd0);
        check("idle_underflow", 64'(underflow_count), 64'd0);
        @(negedge dac_clk);
        check("total_flush", 64'(flush_cnt), 64'd4);
        check("final_sb_empty", 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
